// File: rtl/e203_fpu_fcmp_pkg.sv
// Shared encodings and constants for the FPU single-precision compare path.
package e203_fpu_fcmp_pkg;

    typedef enum logic [1:0] {
        FCMP_FEQ = 2'b00,
        FCMP_FLT = 2'b01,
        FCMP_FLE = 2'b10,
        FCMP_RSV = 2'b11
    } fcmp_op_e;

    localparam int          FFLAG_NV = 4;
    localparam logic [7:0]  EXP_ALL1 = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC00000;

endpackage

// File: rtl/e203_exu_fpu_fcmp_core.sv
// Combinational IEEE-754 single compare: equality, signed-magnitude ordering, NaN classes.
module e203_exu_fpu_fcmp_core
    import e203_fpu_fcmp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        eq,
    output logic        lt,
    output logic        a_nan,
    output logic        b_nan,
    output logic        a_snan,
    output logic        b_snan
);

    logic both_zero;
    logic mag_lt;
    logic mag_gt;

    always_comb begin
        a_nan     = (a[30:23] == EXP_ALL1) && (a[22:0] != 23'd0);
        b_nan     = (b[30:23] == EXP_ALL1) && (b[22:0] != 23'd0);
        a_snan    = a_nan && !a[22];
        b_snan    = b_nan && !b[22];
        both_zero = ((a[30:0] | b[30:0]) == 31'd0);
        eq        = (a == b) || both_zero;
        mag_lt    = (a[30:0] < b[30:0]);
        mag_gt    = (a[30:0] > b[30:0]);
        // Negative operands order by reversed magnitude; -0 vs +0 is not "less".
        case ({a[31], b[31]})
            2'b00:   lt = mag_lt;
            2'b11:   lt = mag_gt;
            2'b10:   lt = !both_zero;
            default: lt = 1'b0;
        endcase
    end

endmodule

// File: rtl/e203_exu_fpu_fcmp_ctrl.sv
// Compare sequencer: one issue stage feeding the compare core, credit-controlled result FIFO.
module e203_exu_fpu_fcmp_ctrl
    import e203_fpu_fcmp_pkg::*;
#(
    parameter int ITAG_W = 4,
    parameter int DEPTH  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [1:0]        i_op,
    input  logic [31:0]       i_rs1,
    input  logic [31:0]       i_rs2,
    input  logic [ITAG_W-1:0] i_itag,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [31:0]       o_wbck_wdat,
    output logic [4:0]        o_fflags,
    output logic [ITAG_W-1:0] o_itag,
    output logic              o_busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              s1_vld_q,  s1_vld_d;
    logic [1:0]        s1_op_q,   s1_op_d;
    logic [31:0]       s1_rs1_q,  s1_rs1_d;
    logic [31:0]       s1_rs2_q,  s1_rs2_d;
    logic [ITAG_W-1:0] s1_itag_q, s1_itag_d;

    logic              res_mem_q  [DEPTH];
    logic              res_mem_d  [DEPTH];
    logic              nv_mem_q   [DEPTH];
    logic              nv_mem_d   [DEPTH];
    logic [ITAG_W-1:0] itag_mem_q [DEPTH];
    logic [ITAG_W-1:0] itag_mem_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    logic [CNT_W:0]    credit_sum;
    logic              i_fire;
    logic              wr_en;
    logic              rd_en;
    logic              eq, lt, a_nan, b_nan, a_snan, b_snan;
    logic              any_nan;
    logic              s1_res;
    logic              s1_nv;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    e203_exu_fpu_fcmp_core u_core (
        .a      (s1_rs1_q),
        .b      (s1_rs2_q),
        .eq     (eq),
        .lt     (lt),
        .a_nan  (a_nan),
        .b_nan  (b_nan),
        .a_snan (a_snan),
        .b_snan (b_snan)
    );

    // Result and invalid flag selection for the op sitting in S1.
    always_comb begin
        any_nan = a_nan | b_nan;
        s1_res  = 1'b0;
        s1_nv   = 1'b0;
        case (s1_op_q)
            FCMP_FEQ: begin
                s1_res = !any_nan && eq;
                s1_nv  = a_snan | b_snan;
            end
            FCMP_FLT: begin
                s1_res = !any_nan && lt;
                s1_nv  = any_nan;
            end
            FCMP_FLE: begin
                s1_res = !any_nan && (lt || eq);
                s1_nv  = any_nan;
            end
            default: begin
                s1_res = 1'b0;
                s1_nv  = 1'b0;
            end
        endcase
    end

    // Credits count both FIFO entries and the S1 op, so S1 can always drain.
    always_comb begin
        credit_sum = {1'b0, cnt_q} + {{CNT_W{1'b0}}, s1_vld_q};
        i_ready    = !flush && (credit_sum < (CNT_W + 1)'(DEPTH));
        i_fire     = i_valid && i_ready;
        o_valid    = (cnt_q != '0);
        wr_en      = s1_vld_q && !flush;
        rd_en      = o_valid && o_ready && !flush;
    end

    always_comb begin
        s1_vld_d  = i_fire;
        s1_op_d   = s1_op_q;
        s1_rs1_d  = s1_rs1_q;
        s1_rs2_d  = s1_rs2_q;
        s1_itag_d = s1_itag_q;
        if (i_fire) begin
            s1_op_d   = i_op;
            s1_rs1_d  = i_rs1;
            s1_rs2_d  = i_rs2;
            s1_itag_d = i_itag;
        end
    end

    always_comb begin
        res_mem_d  = res_mem_q;
        nv_mem_d   = nv_mem_q;
        itag_mem_d = itag_mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_en) begin
                res_mem_d[wptr_q]  = s1_res;
                nv_mem_d[wptr_q]   = s1_nv;
                itag_mem_d[wptr_q] = s1_itag_q;
                wptr_d             = ptr_inc(wptr_q);
            end
            if (rd_en) begin
                rptr_d = ptr_inc(rptr_q);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_op_q   <= '0;
            s1_rs1_q  <= '0;
            s1_rs2_q  <= '0;
            s1_itag_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                res_mem_q[i]  <= 1'b0;
                nv_mem_q[i]   <= 1'b0;
                itag_mem_q[i] <= '0;
            end
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_op_q    <= s1_op_d;
            s1_rs1_q   <= s1_rs1_d;
            s1_rs2_q   <= s1_rs2_d;
            s1_itag_q  <= s1_itag_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            res_mem_q  <= res_mem_d;
            nv_mem_q   <= nv_mem_d;
            itag_mem_q <= itag_mem_d;
        end
    end

    always_comb begin
        o_wbck_wdat           = {31'd0, res_mem_q[rptr_q]};
        o_fflags              = 5'd0;
        o_fflags[FFLAG_NV]    = nv_mem_q[rptr_q];
        o_itag                = itag_mem_q[rptr_q];
        o_busy                = s1_vld_q || o_valid;
    end

endmodule

// File: tb/tb_e203_exu_fpu_fcmp_ctrl.sv
// Self-checking bench for the compare sequencer: directed corner cases, credit/flush/reset, random traffic.
module tb_e203_exu_fpu_fcmp_ctrl;

    localparam int ITAG_W = 4;
    localparam int DEPTH  = 3;
    localparam int W      = 32 + 5 + ITAG_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              i_valid;
    logic              i_ready;
    logic [1:0]        i_op;
    logic [31:0]       i_rs1;
    logic [31:0]       i_rs2;
    logic [ITAG_W-1:0] i_itag;
    logic              o_valid;
    logic              o_ready;
    logic [31:0]       o_wbck_wdat;
    logic [4:0]        o_fflags;
    logic [ITAG_W-1:0] o_itag;
    logic              o_busy;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    bit rnd_on;

    e203_exu_fpu_fcmp_ctrl #(.ITAG_W(ITAG_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_op        (i_op),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .i_itag      (i_itag),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_wbck_wdat (o_wbck_wdat),
        .o_fflags    (o_fflags),
        .o_itag      (o_itag),
        .o_busy      (o_busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Orders floats by mapping each to a signed integer key: +/-0 collapse to 0.
    function automatic logic [1:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        bit     a_nan, b_nan, a_s, b_s;
        longint ka, kb;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_s   = a_nan && !a[22];
        b_s   = b_nan && !b[22];
        ka    = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        kb    = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        case (op)
            2'b00:   return (a_nan || b_nan) ? {1'b0, a_s || b_s} : {ka == kb, 1'b0};
            2'b01:   return (a_nan || b_nan) ? 2'b01 : {ka < kb, 1'b0};
            2'b10:   return (a_nan || b_nan) ? 2'b01 : {ka <= kb, 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] specials [10];
        specials = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000, 32'hC0000000,
                     32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001, 32'hFFA00000};
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 9)];
        return $urandom();
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_valid === 1'b1 && o_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got itag %0h with empty queue", o_itag);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'({o_wbck_wdat, o_fflags, o_itag}), 64'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Tasks start and return at posedge+1; inputs are sampled at negedge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [ITAG_W-1:0] tag, output int waits);
        logic [1:0] r;
        i_valid = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        i_itag  = tag;
        waits   = 0;
        forever begin
            @(negedge clk);
            if (i_ready) begin
                r = ref_model(op, a, b);
                exp_q.push_back({31'd0, r[1], r[0], 4'd0, tag});
                break;
            end
            waits++;
            if (waits > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: itag %0h never accepted", tag);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [ITAG_W-1:0] tag,
                            input logic [31:0] exp_res, input logic [4:0] exp_ff);
        int w;
        send(op, a, b, tag, w);
        @(negedge clk);
        check({name, "_lat1_valid"}, 64'(o_valid), 64'd0);
        @(negedge clk);
        check({name, "_lat2_valid"}, 64'(o_valid), 64'd1);
        check({name, "_wdat"}, 64'(o_wbck_wdat), 64'(exp_res));
        check({name, "_fflags"}, 64'(o_fflags), 64'(exp_ff));
        check({name, "_itag"}, 64'(o_itag), 64'(tag));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w;
        int wsum;
        rst_n   = 1'b0;
        flush   = 1'b0;
        i_valid = 1'b0;
        i_op    = '0;
        i_rs1   = '0;
        i_rs2   = '0;
        i_itag  = '0;
        o_ready = 1'b0;
        #1;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_busy", 64'(o_busy), 64'd0);
        check("rst_wdat", 64'(o_wbck_wdat), 64'd0);
        check("rst_fflags", 64'(o_fflags), 64'd0);
        check("rst_itag", 64'(o_itag), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_i_ready", 64'(i_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed compare corners with latency check.
        o_ready = 1'b1;
        directed("feq_pm0",   2'b00, 32'h80000000, 32'h00000000, 4'h5, 32'd1, 5'h00);
        directed("flt_neg",   2'b01, 32'hBF800000, 32'hC0000000, 4'h6, 32'd0, 5'h00);
        directed("fle_neg",   2'b10, 32'hC0000000, 32'hBF800000, 4'h7, 32'd1, 5'h00);
        directed("flt_eq",    2'b01, 32'h3F800000, 32'h3F800000, 4'h8, 32'd0, 5'h00);
        directed("feq_qnan",  2'b00, 32'h7FC00000, 32'h3F800000, 4'h9, 32'd0, 5'h00);
        directed("flt_qnan",  2'b01, 32'h7FC00000, 32'h3F800000, 4'hA, 32'd0, 5'h10);
        directed("feq_snan",  2'b00, 32'h7F800001, 32'h3F800000, 4'hB, 32'd0, 5'h10);
        directed("rsv_snan",  2'b11, 32'h7F800001, 32'h3F800000, 4'hC, 32'd0, 5'h00);
        directed("fle_pm0",   2'b10, 32'h80000000, 32'h00000000, 4'hD, 32'd1, 5'h00);
        directed("flt_pm0",   2'b01, 32'h80000000, 32'h00000000, 4'hE, 32'd0, 5'h00);
        directed("flt_posit", 2'b01, 32'h3F800000, 32'h40000000, 4'hF, 32'd1, 5'h00);

        // Backpressure: three accepts fill the credits, the fourth waits.
        o_ready = 1'b0;
        wsum = 0;
        for (int t = 1; t <= 3; t++) begin
            send(2'b10, rand_operand(), rand_operand(), ITAG_W'(t), w);
            wsum += w;
        end
        check("fill_no_wait", 64'(wsum), 64'd0);
        @(negedge clk);
        check("credit_full_i_ready", 64'(i_ready), 64'd0);
        @(posedge clk);
        #1;
        fork
            begin
                send(2'b00, 32'h3F800000, 32'h3F800000, 4'd4, w);
                check("itag4_waited", 64'(w > 0), 64'd1);
            end
            begin
                idle(2);
                o_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("stream_no_bubble", 64'(o_valid), 64'd1);
                end
            end
        join
        @(posedge clk);
        #1;
        drain();

        // Sustained back-to-back traffic with the sink always ready.
        o_ready = 1'b1;
        wsum = 0;
        for (int t = 0; t < 12; t++) begin
            send(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), ITAG_W'(t), w);
            wsum += w;
        end
        check("sustained_no_wait", 64'(wsum), 64'd0);
        drain();

        // Flush with an empty pipe: op offered in the flush cycle is dropped.
        flush   = 1'b1;
        i_valid = 1'b1;
        i_op    = 2'b00;
        i_rs1   = 32'h0;
        i_rs2   = 32'h0;
        i_itag  = 4'h3;
        @(negedge clk);
        check("flush_empty_i_ready", 64'(i_ready), 64'd0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("flush_empty_no_output", 64'({o_valid, o_busy}), 64'd0);
        @(posedge clk);
        #1;

        // Flush with S1 full and two FIFO entries.
        o_ready = 1'b0;
        for (int t = 9; t <= 11; t++) send(2'b01, rand_operand(), rand_operand(), ITAG_W'(t), w);
        flush   = 1'b1;
        i_valid = 1'b1;
        i_op    = 2'b10;
        i_rs1   = 32'h0;
        i_rs2   = 32'h0;
        i_itag  = 4'hC;
        @(negedge clk);
        check("flush_full_busy_before", 64'(o_busy), 64'd1);
        check("flush_full_i_ready", 64'(i_ready), 64'd0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        i_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_o_valid", 64'(o_valid), 64'd0);
        check("flush_o_busy", 64'(o_busy), 64'd0);
        @(posedge clk);
        #1;
        o_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("flush_op_dropped", 64'(o_valid), 64'd0);
        @(posedge clk);
        #1;

        // Random traffic with random backpressure and gaps.
        rnd_on = 1'b1;
        fork
            begin
                for (int t = 0; t < 300; t++) begin
                    send(2'($urandom_range(0, 3)), rand_operand(),
                         ($urandom_range(0, 5) == 0) ? i_rs1 : rand_operand(),
                         ITAG_W'($urandom()), w);
                    idle($urandom_range(0, 2));
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    o_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk);
        #1;
        o_ready = 1'b1;
        drain();

        // Asynchronous reset mid-stream.
        o_ready = 1'b0;
        send(2'b01, 32'hBF800000, 32'h3F800000, 4'h1, w);
        send(2'b00, 32'h3F800000, 32'h3F800000, 4'h2, w);
        @(negedge clk);
        check("busy_before_reset", 64'(o_busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_o_valid", 64'(o_valid), 64'd0);
        check("async_rst_o_busy", 64'(o_busy), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        o_ready = 1'b1;
        @(negedge clk);
        check("post_rst_i_ready", 64'(i_ready), 64'd1);
        @(posedge clk);
        #1;
        directed("post_rst_fle", 2'b10, 32'hC0000000, 32'hBF800000, 4'h7, 32'd1, 5'h00);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e203_exu_fpu_fcmp_ctrl.md
Name: e203_exu_fpu_fcmp_ctrl

Overview:
- Sequencing controller for the FPU single-precision compare datapath (FEQ.S / FLT.S / FLE.S).
- Accepts compare ops from the EXU FPU dispatch over a valid/ready handshake and registers operands in one issue stage.
- Drives one shared compare core, adds RISC-V NaN handling and the invalid flag, and queues results in an output FIFO toward the FPU writeback arbiter.
- Flow control is credit-based: there is no combinational path from o_ready to i_ready.

Parameters:
- ITAG_W, 4, width of the instruction tag carried with each op.
- DEPTH, 3, output FIFO entries; must be ≥ 3 for one op per cycle sustained throughput.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush; discards all in-flight ops
- i_valid  in  1  op request valid
- i_ready  out  1  op accepted when i_valid & i_ready
- i_op  in  2  00 FEQ, 01 FLT, 10 FLE, 11 reserved
- i_rs1  in  32  operand a (IEEE-754 single)
- i_rs2  in  32  operand b
- i_itag  in  ITAG_W  tag returned with the result
- o_valid  out  1  result valid (FIFO head)
- o_ready  in  1  writeback accepts result
- o_wbck_wdat  out  32  result, 0 or 1 zero-extended
- o_fflags  out  5  {NV,DZ,OF,UF,NX}; only NV may be set
- o_itag  out  ITAG_W  tag of the result
- o_busy  out  1  any op in the issue stage or FIFO

Behaviour:
- Reset: s1_vld=0, FIFO count=0, pointers=0. o_valid=0, o_busy=0. i_ready=1 once reset is released. Data outputs are 0.
- Issue stage S1: on i_fire, capture op, rs1, rs2 and itag; set s1_vld. With no new i_fire, s1_vld clears the next cycle. S1 always drains: the credit rule guarantees FIFO space.
- Credit rule: i_ready = ~flush & ((cnt + s1_vld) < DEPTH). Uses registered state only.
- Latency: an op accepted in cycle N presents o_valid in cycle N+2 (S1 compute in N+1, FIFO write at end of N+1).
- Output: o_valid = (cnt != 0). Head stays stable while o_valid & ~o_ready.
- Simultaneous FIFO write and read: cnt unchanged; pointers wrap modulo DEPTH.
- Compare core outputs:
  - a_nan: exp=FF and mant≠0.
  - a_snan: a_nan and mant[22]=0.
  - eq: (a==b) | (a|b)[30:0]==0, so +0 equals −0.
  - lt: signed-magnitude ordering. −0 < +0 is false. Both-negative comparison is reversed.
- Result by op:
  - FEQ: any NaN → 0; else eq. NV = a_snan | b_snan.
  - FLT: any NaN → 0, NV=1; else lt.
  - FLE: any NaN → 0, NV=1; else lt | eq.
  - Reserved op 11: result 0, NV=0.
- flush: clears s1_vld and cnt/pointers in the same edge. i_ready is forced 0 during the flush cycle, so an op presented then is not accepted. o_valid drops the cycle after flush.
- Reset mid-operation: all in-flight ops are lost; outputs return to reset values asynchronously.

Decomposition:
- Package e203_fpu_fcmp_pkg holds:
  - op encodings FCMP_FEQ=2'b00, FCMP_FLT=2'b01, FCMP_FLE=2'b10
  - FFLAG_NV bit index 4
  - EXP_ALL1=8'hFF
  - canonical QNAN=32'h7FC00000
- One combinational sub-module, e203_exu_fpu_fcmp_core: inputs a, b; outputs eq, lt, a_nan, b_nan, a_snan, b_snan. The controller owns S1, the FIFO, credits and op selection.

Test Plan:
- FEQ with rs1=32'h80000000, rs2=32'h00000000 → result 1, fflags 0, o_valid exactly 2 cycles after accept.
- FLT with rs1=32'hBF800000 (−1.0), rs2=32'hC0000000 (−2.0) → 0. FLE with rs1=32'hC0000000, rs2=32'hBF800000 → 1. FLT with rs1=rs2=32'h3F800000 → 0.
- FEQ with rs1=32'h7FC00000 (qNaN), rs2=32'h3F800000 → 0, NV=0. Same operands with FLT → 0, NV=1 (fflags 5'h10). FEQ with rs1=32'h7F800001 (sNaN) → 0, NV=1.
- Hold o_ready=0 and stream ops with itags 1,2,3,4 → i_ready falls after 3 accepts and itag 4 waits. Release o_ready → results exit in order 1,2,3,4 at one per cycle with no bubble once streaming.
- Back-to-back ops with o_ready=1, DEPTH=3 → sustained one accept and one result per cycle. i_ready never depends on same-cycle o_ready.
- Assert flush with S1 full and 2 FIFO entries → o_valid=0 and o_busy=0 the next cycle. The op presented during flush is not accepted.
- Deassert rst_n mid-stream → o_valid and o_busy fall immediately. After release, the first new op returns the correct result and itag.
